apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arb_pkg.sv | 13 +
 rtl/apb_arbiter_rr_picker.sv | 32 +++
 rtl/apb_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   localparam int DEF_TIMEOUT_CYCLES = 256;

   // Index width that stays legal for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_arbiter_rr_picker.sv
// Round-robin picker: first requester found searching upward from last_owner+1.
module rr_picker
   import apb_arb_pkg::*;
#(
   parameter int NR_REQ = 4,
   parameter int IW     = idx_w(NR_REQ)
) (
   input  logic [NR_REQ-1:0] req,
   input  logic [IW-1:0]     last_owner,
   output logic [NR_REQ-1:0] gnt,
   output logic [IW-1:0]     idx
);

   int   c;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 1; k <= NR_REQ; k++) begin
         c = (int'(last_owner) + k) % NR_REQ;
         if (!found && req[c]) begin
            found = 1'b1;
            gnt   = NR_REQ'(1) << c;
            idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/apb_arbiter.sv
// Multi-requester front end for one APB master control port.
// Optional wait timeout: define APB_ARB_TIMEOUT_EN.
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NR_REQ         = 4,
   parameter int NR_SLAVES      = 1,
   parameter int ADDR_WIDTH     = 5,
   parameter int WDATA_WIDTH    = 32,
   parameter int RDATA_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NR_REQ-1:0]              req_valid,
   input  logic [NR_REQ*NR_SLAVES-1:0]    req_sel,
   input  logic [NR_REQ-1:0]              req_wr_rd,
   input  logic [NR_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NR_REQ*WDATA_WIDTH-1:0]  req_wdata,
   output logic [NR_REQ-1:0]              req_grant,
   output logic [NR_REQ-1:0]              rsp_valid,
   output logic [RDATA_WIDTH-1:0]         rsp_rdata,
   output logic                           rsp_err,
   output logic                           busy,
   output logic                           ctrl_req,
   output logic [NR_SLAVES-1:0]           ctrl_sel,
   output logic                           ctrl_wr_rd,
   output logic [ADDR_WIDTH-1:0]          ctrl_addr,
   output logic [WDATA_WIDTH-1:0]         ctrl_wdata,
   input  logic [RDATA_WIDTH-1:0]         ctrl_rdata,
   input  logic                           ctrl_ready
);

   localparam int IW = idx_w(NR_REQ);

   arb_state_e              state;
   logic [IW-1:0]           own_idx, last_owner;
   logic [NR_REQ-1:0]       own_oh;
   logic [NR_REQ-1:0]       pick_gnt;
   logic [IW-1:0]           pick_idx;
   logic [NR_SLAVES-1:0]    pick_sel;
   logic                    pick_wr;
   logic [ADDR_WIDTH-1:0]   pick_addr;
   logic [WDATA_WIDTH-1:0]  pick_wdata;
   logic                    tmo;

   rr_picker #(.NR_REQ(NR_REQ), .IW(IW)) u_pick (
      .req        (req_valid),
      .last_owner (last_owner),
      .gnt        (pick_gnt),
      .idx        (pick_idx)
   );

   // One-hot grant makes the field select a plain AND-OR mux.
   always_comb begin
      pick_sel   = '0;
      pick_wr    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         if (pick_gnt[i]) begin
            pick_sel   = pick_sel   | req_sel[i*NR_SLAVES +: NR_SLAVES];
            pick_wr    = pick_wr    | req_wr_rd[i];
            pick_addr  = pick_addr  | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            pick_wdata = pick_wdata | req_wdata[i*WDATA_WIDTH +: WDATA_WIDTH];
         end
      end
   end

   assign own_oh = NR_REQ'(1) << own_idx;
   assign busy   = (state != IDLE);

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   assign tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   // ctrl_* double as the owner's latched fields; they are cleared on leaving RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         own_idx    <= '0;
         last_owner <= IW'(NR_REQ - 1);
         req_grant  <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         ctrl_req   <= 1'b0;
         ctrl_sel   <= '0;
         ctrl_wr_rd <= 1'b0;
         ctrl_addr  <= '0;
         ctrl_wdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         tcnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (|req_valid) begin
               state      <= ISSUE;
               own_idx    <= pick_idx;
               req_grant  <= pick_gnt;
               ctrl_req   <= |pick_sel;
               ctrl_sel   <= pick_sel;
               ctrl_wr_rd <= pick_wr;
               ctrl_addr  <= pick_addr;
               ctrl_wdata <= pick_wdata;
            end
            ISSUE: begin
               req_grant <= '0;
               ctrl_req  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
               tcnt      <= '0;
`endif
               if (ctrl_sel == '0) begin
                  state     <= RESP;
                  rsp_valid <= own_oh;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (ctrl_ready) begin
                  state     <= RESP;
                  rsp_valid <= own_oh;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= ctrl_wr_rd ? '0 : ctrl_rdata;
               end else if (tmo) begin
                  state     <= RESP;
                  rsp_valid <= own_oh;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
`ifdef APB_ARB_TIMEOUT_EN
                  tcnt <= tcnt + 1'b1;
`endif
               end
            end
            RESP: begin
               state      <= IDLE;
               last_owner <= own_idx;
               rsp_valid  <= '0;
               rsp_err    <= 1'b0;
               rsp_rdata  <= '0;
               ctrl_sel   <= '0;
               ctrl_wr_rd <= 1'b0;
               ctrl_addr  <= '0;
               ctrl_wdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed + randomized bench for apb_arbiter against a transaction-level model.
module tb_apb_arbiter;

   localparam int NR = 4, NS = 2, AW = 5, WW = 32, RW = 32, TMO = 8;
`ifdef APB_ARB_TIMEOUT_EN
   localparam int WR_HOLD = 6;
`else
   localparam int WR_HOLD = 10;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid, req_wr_rd, req_grant, rsp_valid;
   logic [NR*NS-1:0]  req_sel;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*WW-1:0]  req_wdata;
   logic [RW-1:0]     rsp_rdata, ctrl_rdata;
   logic              rsp_err, busy, ctrl_req, ctrl_wr_rd, ctrl_ready;
   logic [NS-1:0]     ctrl_sel;
   logic [AW-1:0]     ctrl_addr;
   logic [WW-1:0]     ctrl_wdata;

   logic [NS-1:0]     f_sel  [NR];
   logic              f_wr   [NR];
   logic [AW-1:0]     f_addr [NR];
   logic [WW-1:0]     f_wd   [NR];

   int nvec = 0, nerr = 0, m_last = NR - 1;

   always #5 clk = ~clk;

   apb_arbiter #(
      .NR_REQ(NR), .NR_SLAVES(NS), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW),
      .RDATA_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
      .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy), .ctrl_req(ctrl_req), .ctrl_sel(ctrl_sel),
      .ctrl_wr_rd(ctrl_wr_rd), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
      .ctrl_rdata(ctrl_rdata), .ctrl_ready(ctrl_ready)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_ctrl_req"}, 64'(ctrl_req), 64'd0);
      chk({tag, "_ctrl_sel"}, 64'(ctrl_sel), 64'd0);
      chk({tag, "_ctrl_wr"}, 64'(ctrl_wr_rd), 64'd0);
      chk({tag, "_ctrl_addr"}, 64'(ctrl_addr), 64'd0);
      chk({tag, "_ctrl_wdata"}, 64'(ctrl_wdata), 64'd0);
      chk({tag, "_grant"}, 64'(req_grant), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
      chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
   endtask

   task automatic drive(input logic [NR-1:0] v);
      req_valid = v;
      for (int i = 0; i < NR; i++) begin
         req_sel[i*NS +: NS]   = f_sel[i];
         req_wr_rd[i]          = f_wr[i];
         req_addr[i*AW +: AW]  = f_addr[i];
         req_wdata[i*WW +: WW] = f_wd[i];
      end
   endtask

   // Priority list starts just after the previous owner and wraps around.
   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      int order[$];
      for (int k = 1; k <= NR; k++) order.push_back((last + k) % NR);
      foreach (order[j]) if (v[order[j]]) return order[j];
      return -1;
   endfunction

   task automatic do_reset;
      rst = 1'b1; req_valid = '0; ctrl_ready = 1'b0;
      tick; tick;
      rst = 1'b0;
      m_last = NR - 1;
   endtask

   // One full transaction from IDLE back to IDLE; ready comes after nw extra WAIT cycles.
   task automatic do_txn(input logic [NR-1:0] v, input int nw, input logic [RW-1:0] rd);
      int   w;
      logic zs;
      w  = rr_pick(v, m_last);
      zs = (f_sel[w] == '0);
      drive(v);
      ctrl_ready = 1'($urandom_range(0, 1));
      ctrl_rdata = $urandom;
      tick;
      chk("iss_grant", 64'(req_grant), 64'd1 << w);
      chk("iss_ctrl_req", 64'(ctrl_req), 64'(!zs));
      chk("iss_sel", 64'(ctrl_sel), 64'(f_sel[w]));
      chk("iss_wr", 64'(ctrl_wr_rd), 64'(f_wr[w]));
      chk("iss_addr", 64'(ctrl_addr), 64'(f_addr[w]));
      chk("iss_wdata", 64'(ctrl_wdata), 64'(f_wd[w]));
      chk("iss_busy", 64'(busy), 64'd1);
      chk("iss_rsp_valid", 64'(rsp_valid), 64'd0);
      req_valid = NR'($urandom);
      tick;
      if (!zs) begin
         for (int k = 0; k <= nw; k++) begin
            chk("wait_ctrl_req", 64'(ctrl_req), 64'd0);
            chk("wait_grant", 64'(req_grant), 64'd0);
            chk("wait_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("wait_sel", 64'(ctrl_sel), 64'(f_sel[w]));
            chk("wait_addr", 64'(ctrl_addr), 64'(f_addr[w]));
            chk("wait_wdata", 64'(ctrl_wdata), 64'(f_wd[w]));
            ctrl_ready = (k == nw);
            ctrl_rdata = (k == nw) ? rd : $urandom;
            req_valid  = NR'($urandom);
            tick;
         end
      end
      chk("rsp_valid", 64'(rsp_valid), 64'd1 << w);
      chk("rsp_err", 64'(rsp_err), 64'(zs));
      chk("rsp_rdata", 64'(rsp_rdata), (zs || f_wr[w]) ? 64'd0 : 64'(rd));
      chk("rsp_ctrl_req", 64'(ctrl_req), 64'd0);
      chk("rsp_grant", 64'(req_grant), 64'd0);
      ctrl_ready = 1'b0;
      req_valid  = '0;
      tick;
      chk_idle("idle");
      m_last = w;
   endtask

   initial begin
      rst = 1'b1; ctrl_ready = 1'b0; ctrl_rdata = '0;
      for (int i = 0; i < NR; i++) begin
         f_sel[i] = '0; f_wr[i] = 1'b0; f_addr[i] = '0; f_wd[i] = '0;
      end
      drive('0);
      tick; tick;
      chk_idle("reset");
      rst = 1'b0;
      tick;
      chk_idle("post_reset");

      // single read from requester 2, ready three cycles after ctrl_req
      f_sel[2] = 2'b01; f_addr[2] = 5'h0A; f_wr[2] = 1'b0; f_wd[2] = 32'h0;
      do_txn(4'b0100, 2, 32'h12345678);

      // full contention from reset: 0,1,2,3,0
      do_reset;
      for (int i = 0; i < NR; i++) begin
         f_sel[i] = 2'b10; f_wr[i] = 1'b0; f_addr[i] = AW'(i + 3); f_wd[i] = $urandom;
      end
      for (int n = 0; n < 5; n++) do_txn(4'b1111, 0, $urandom);

      // long write wait
      f_sel[1] = 2'b01; f_addr[1] = 5'h1F; f_wd[1] = 32'hCAFEF00D; f_wr[1] = 1'b1;
      do_txn(4'b0010, WR_HOLD - 1, 32'hDEADBEEF);

      // zero select
      f_sel[3] = 2'b00; f_wr[3] = 1'b0;
      do_txn(4'b1000, 0, 32'h55AA55AA);

      // reset in the middle of WAIT
      f_sel[1] = 2'b01; f_wr[1] = 1'b0;
      drive(4'b0010);
      tick;
      chk("rstw_grant", 64'(req_grant), 64'b0010);
      req_valid = '0;
      tick; tick;
      chk("rstw_busy_wait", 64'(busy), 64'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rstw_busy", 64'(busy), 64'd0);
      chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
      tick;
      chk("rstw_rsp_valid2", 64'(rsp_valid), 64'd0);
      m_last = NR - 1;
      do_txn(4'b1111, 1, $urandom);

`ifdef APB_ARB_TIMEOUT_EN
      f_sel[0] = 2'b01; f_wr[0] = 1'b0;
      drive(4'b0001);
      tick;
      req_valid = '0;
      tick;
      for (int k = 0; k < TMO; k++) begin
         chk("tmo_wait", 64'(rsp_valid), 64'd0);
         tick;
      end
      chk("tmo_rsp_valid", 64'(rsp_valid), 64'b0001);
      chk("tmo_err", 64'(rsp_err), 64'd1);
      chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
      tick;
      m_last = 0;
`endif

      // randomized traffic
      repeat (40) begin
         for (int i = 0; i < NR; i++) begin
            f_sel[i]  = NS'($urandom_range(0, 3));
            f_wr[i]   = 1'($urandom_range(0, 1));
            f_addr[i] = AW'($urandom);
            f_wd[i]   = $urandom;
         end
         do_txn(NR'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
